// File: rtl/puf_sequencer.sv
// Host-side sequencer for puf_parallel: synchronizes host request/ack, settles the
// challenge, runs one evaluation with timeout/abort, and holds the response for the host.
module puf_sequencer #(
   parameter int unsigned CHAL_W         = 8,
   parameter int unsigned RESP_W         = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic              host_ack,
   input  logic [CHAL_W-1:0] challenge_in,
   input  logic              puf_done,
   input  logic [RESP_W-1:0] puf_response,
   output logic [CHAL_W-1:0] puf_challenge,
   output logic              puf_enable,
   output logic [RESP_W-1:0] response_out,
   output logic              resp_valid,
   output logic              timeout,
   output logic              busy
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                       : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_RUN     = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] req_sync_q, ack_sync_q;
   logic                req_dly_q;
   logic                req_s, ack_s, req_rise;
   logic [CHAL_W-1:0]   chal_q, chal_d;
   logic [RESP_W-1:0]   resp_q, resp_d;
   logic                en_q, en_d;
   logic                valid_q, valid_d;
   logic                tmo_q, tmo_d;
   logic                busy_q, busy_d;

   assign req_s    = req_sync_q[SYNC_STAGES-1];
   assign ack_s    = ack_sync_q[SYNC_STAGES-1];
   assign req_rise = req_s & ~req_dly_q;

   // Host pin synchronizers and request edge history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_sync_q <= '0;
         ack_sync_q <= '0;
         req_dly_q  <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], host_req};
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], host_ack};
         req_dly_q  <= req_s;
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         chal_q  <= '0;
         resp_q  <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chal_q  <= chal_d;
         resp_q  <= resp_d;
         en_q    <= en_d;
         valid_q <= valid_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chal_d  = chal_q;
      resp_d  = resp_q;
      en_d    = en_q;
      valid_d = valid_q;
      tmo_d   = tmo_q;

      case (state_q)
         ST_IDLE: begin
            en_d    = 1'b0;
            valid_d = 1'b0;
            if (req_rise) begin
               chal_d  = challenge_in;
               tmo_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            en_d = 1'b0;
            if (!req_s) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               en_d    = 1'b1;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // A dropped request abandons the evaluation; done beats timeout otherwise
            if (!req_s) begin
               en_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (puf_done) begin
               resp_d  = puf_response;
               valid_d = 1'b1;
               en_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               resp_d  = '0;
               tmo_d   = 1'b1;
               valid_d = 1'b1;
               en_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (ack_s) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!ack_s && !req_s) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            chal_d  = '0;
            resp_d  = '0;
            en_d    = 1'b0;
            valid_d = 1'b0;
            tmo_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign puf_challenge = chal_q;
   assign puf_enable    = en_q;
   assign response_out  = resp_q;
   assign resp_valid    = valid_q;
   assign timeout       = tmo_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_puf_sequencer.sv
// Bench for puf_sequencer: a timeline model schedules expected output changes from
// host-pin event times; a negedge process compares every cycle, plus literal pin checks.
module tb_puf_sequencer;

   localparam int unsigned CW   = 8;
   localparam int unsigned RW   = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned SET  = 4;
   localparam int unsigned TMO  = 16;

   localparam int F_CHAL  = 0;
   localparam int F_EN    = 1;
   localparam int F_RESP  = 2;
   localparam int F_VALID = 3;
   localparam int F_TMO   = 4;
   localparam int F_BUSY  = 5;

   logic          clk;
   logic          rst_n;
   logic          host_req;
   logic          host_ack;
   logic [CW-1:0] challenge_in;
   logic          puf_done;
   logic [RW-1:0] puf_response;
   logic [CW-1:0] puf_challenge;
   logic          puf_enable;
   logic [RW-1:0] response_out;
   logic          resp_valid;
   logic          timeout;
   logic          busy;

   puf_sequencer #(
      .CHAL_W(CW), .RESP_W(RW), .SYNC_STAGES(SYNC),
      .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_ack(host_ack),
      .challenge_in(challenge_in), .puf_done(puf_done), .puf_response(puf_response),
      .puf_challenge(puf_challenge), .puf_enable(puf_enable), .response_out(response_out),
      .resp_valid(resp_valid), .timeout(timeout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         t;
      int         f;
      logic [7:0] v;
   } ev_t;

   ev_t        evq[$];
   int         cyc;
   int         total;
   int         bad;
   bit         chk_en;
   logic [7:0] m_chal, m_resp;
   logic       m_en, m_valid, m_tmo, m_busy;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic sched(int t, int f, logic [7:0] v);
      ev_t e;
      e.t = t;
      e.f = f;
      e.v = v;
      evq.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_zero();
      m_chal  = '0;
      m_resp  = '0;
      m_en    = 1'b0;
      m_valid = 1'b0;
      m_tmo   = 1'b0;
      m_busy  = 1'b0;
   endtask

   // Model: apply the expected changes scheduled for this clock edge
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < evq.size(); ) begin
            if (evq[i].t == cyc) begin
               case (evq[i].f)
                  F_CHAL:  m_chal  = evq[i].v;
                  F_EN:    m_en    = evq[i].v[0];
                  F_RESP:  m_resp  = evq[i].v;
                  F_VALID: m_valid = evq[i].v[0];
                  F_TMO:   m_tmo   = evq[i].v[0];
                  default: m_busy  = evq[i].v[0];
               endcase
               evq.delete(i);
            end else begin
               i++;
            end
         end
      end
   end

   // Compare every output against the model on each falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("cyc_chal",  32'(puf_challenge), 32'(m_chal));
            check("cyc_en",    32'(puf_enable),    32'(m_en));
            check("cyc_resp",  32'(response_out),  32'(m_resp));
            check("cyc_valid", 32'(resp_valid),    32'(m_valid));
            check("cyc_tmo",   32'(timeout),       32'(m_tmo));
            check("cyc_busy",  32'(busy),          32'(m_busy));
         end
      end
   end

   // Request accepted SYNC+1 edges after the pin edge; enable follows SET edges later
   task automatic start_req(logic [7:0] ch, output int run_edge);
      int k;
      k            = cyc;
      challenge_in = ch;
      host_req     = 1'b1;
      sched(k + SYNC + 1, F_CHAL, ch);
      sched(k + SYNC + 1, F_BUSY, 8'd1);
      sched(k + SYNC + 1, F_TMO,  8'd0);
      run_edge = k + SYNC + 1 + SET;
      sched(run_edge, F_EN, 8'd1);
   endtask

   task automatic handshake();
      int a;
      a        = cyc;
      host_ack = 1'b1;
      sched(a + SYNC + 1, F_VALID, 8'd0);
      tick(SYNC + 1);
      check("hs_valid_cleared", 32'(resp_valid), 32'd0);
      tick(2);
      a        = cyc;
      host_ack = 1'b0;
      host_req = 1'b0;
      sched(a + SYNC + 1, F_BUSY, 8'd0);
      tick(SYNC + 1);
      check("hs_idle", 32'(busy), 32'd0);
      tick(3);
   endtask

   initial begin
      int r, b, n;
      total = 0; bad = 0; chk_en = 1'b0;
      host_req = 1'b0; host_ack = 1'b0; challenge_in = '0;
      puf_done = 1'b0; puf_response = '0;
      model_zero();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_en",    32'(puf_enable),    32'd0);
      check("rst_valid", 32'(resp_valid),    32'd0);
      check("rst_busy",  32'(busy),          32'd0);
      check("rst_chal",  32'(puf_challenge), 32'd0);
      chk_en = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(3);

      // Normal evaluation: A5 -> 3C, done seen 10 cycles into RUN
      start_req(8'hA5, r);
      puf_response = 8'h3C;
      tick(6);
      check("norm_en_low_at_6", 32'(puf_enable), 32'd0);
      tick(1);
      check("norm_en_high_at_7", 32'(puf_enable), 32'd1);
      tick(9);
      puf_done = 1'b1;
      sched(r + 10, F_EN, 8'd0);
      sched(r + 10, F_VALID, 8'd1);
      sched(r + 10, F_RESP, 8'h3C);
      tick(1);
      puf_done = 1'b0;
      check("norm_resp",  32'(response_out),  32'h3C);
      check("norm_valid", 32'(resp_valid),    32'd1);
      check("norm_tmo",   32'(timeout),       32'd0);
      check("norm_chal",  32'(puf_challenge), 32'hA5);
      tick(2);

      // Ack held with request still high: no new run may start
      b = cyc;
      host_ack = 1'b1;
      sched(b + SYNC + 1, F_VALID, 8'd0);
      tick(12);
      check("held_busy", 32'(busy), 32'd1);
      check("held_en",   32'(puf_enable), 32'd0);
      check("held_valid", 32'(resp_valid), 32'd0);
      b = cyc;
      host_ack = 1'b0;
      host_req = 1'b0;
      sched(b + SYNC + 1, F_BUSY, 8'd0);
      tick(6);
      check("released_busy", 32'(busy), 32'd0);

      // Timeout: done never arrives
      start_req(8'hC3, r);
      sched(r + TMO, F_EN, 8'd0);
      sched(r + TMO, F_TMO, 8'd1);
      sched(r + TMO, F_RESP, 8'd0);
      sched(r + TMO, F_VALID, 8'd1);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (puf_enable) n++;
      end
      check("tmo_en_cycles", 32'(n), 32'd16);
      check("tmo_flag",  32'(timeout),      32'd1);
      check("tmo_resp",  32'(response_out), 32'd0);
      check("tmo_valid", 32'(resp_valid),   32'd1);
      handshake();
      check("tmo_sticky", 32'(timeout), 32'd1);

      // Done coincides with the last timeout cycle: done wins
      start_req(8'h5A, r);
      puf_response = 8'h77;
      tick(SYNC + 1 + SET + TMO - 1);
      puf_done = 1'b1;
      sched(r + TMO, F_EN, 8'd0);
      sched(r + TMO, F_VALID, 8'd1);
      sched(r + TMO, F_RESP, 8'h77);
      tick(1);
      puf_done = 1'b0;
      check("sim_resp",  32'(response_out),  32'h77);
      check("sim_tmo",   32'(timeout),       32'd0);
      check("sim_chal",  32'(puf_challenge), 32'h5A);
      check("sim_valid", 32'(resp_valid),    32'd1);
      handshake();

      // Abort: request drops three cycles into RUN
      start_req(8'h99, r);
      tick(SYNC + 1 + SET + 3);
      b = cyc;
      host_req = 1'b0;
      sched(b + SYNC + 1, F_EN, 8'd0);
      sched(b + SYNC + 1, F_BUSY, 8'd0);
      tick(SYNC + 1);
      check("abort_en",    32'(puf_enable),    32'd0);
      check("abort_busy",  32'(busy),          32'd0);
      check("abort_valid", 32'(resp_valid),    32'd0);
      check("abort_resp",  32'(response_out),  32'h77);
      check("abort_chal",  32'(puf_challenge), 32'h99);
      tick(4);

      // Asynchronous reset in the middle of RUN
      start_req(8'h11, r);
      tick(SYNC + 1 + SET + 5);
      check("pre_rst_en", 32'(puf_enable), 32'd1);
      rst_n    = 1'b0;
      host_req = 1'b0;
      evq.delete();
      model_zero();
      #1;
      check("mid_rst_en",    32'(puf_enable), 32'd0);
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),       32'd0);
      check("mid_rst_tmo",   32'(timeout),    32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(6);
      check("post_rst_busy", 32'(busy),       32'd0);
      check("post_rst_en",   32'(puf_enable), 32'd0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
